// File: rtl/booth_multiplier_if.sv
// Start/operand/result bundle between the issuing datapath and the Booth multiplier.
interface booth_multiplier_if #(parameter int WIDTH = 32);
  logic             ctrl_MULT;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;

  modport master (
    output ctrl_MULT, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY
  );
  modport slave (
    input  ctrl_MULT, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY
  );
endinterface

// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier: one add/sub plus one arithmetic shift per cycle.
// Define MULT_OVF_EN to latch signed overflow into data_exception; otherwise it is tied to 0.
module booth_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  booth_multiplier_if.slave   bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH:0]   m_q, m_d, acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d, res_q, res_d;
  logic             q1_q, q1_d, rdy_q, rdy_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH:0]   acc_add, acc_sh;
  logic [WIDTH-1:0] q_sh;
  logic             last_edge, start;

  assign start     = bus.ctrl_MULT;
  assign last_edge = (state_q == S_RUN) && (cnt_q == CW'(WIDTH - 1)) && !start;

  // Acc stays WIDTH+1 bits so that negating M = -2^(WIDTH-1) is exact.
  always_comb begin
    acc_add = acc_q;
    case ({q_q[0], q1_q})
      2'b01:   acc_add = acc_q + m_q;
      2'b10:   acc_add = acc_q - m_q;
      default: acc_add = acc_q;
    endcase
    acc_sh = {acc_add[WIDTH], acc_add[WIDTH:1]};
    q_sh   = {acc_add[0], q_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    rdy_d   = 1'b0;
    if (start) begin
      // A restart always wins, discarding any operation in flight.
      state_d = S_RUN;
      m_d     = {bus.data_operandA[WIDTH-1], bus.data_operandA};
      acc_d   = '0;
      q_d     = bus.data_operandB;
      q1_d    = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_RUN: begin
          acc_d = acc_sh;
          q_d   = q_sh;
          q1_d  = q_q[0];
          cnt_d = cnt_q + 1'b1;
          if (last_edge) begin
            state_d = S_DONE;
            res_d   = q_sh;
            rdy_d   = 1'b1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      rdy_q   <= rdy_d;
    end
  end

  assign bus.data_result    = res_q;
  assign bus.data_resultRDY = rdy_q;

`ifdef MULT_OVF_EN
  logic exc_q, exc_d;
  logic [WIDTH:0] hi_bits;

  // Product bits [2W-1:W-1] must all match the sign for the low half to be exact.
  assign hi_bits = {acc_sh[WIDTH-1:0], q_sh[WIDTH-1]};

  always_comb begin
    exc_d = exc_q;
    if (start)          exc_d = 1'b0;
    else if (last_edge) exc_d = !((&hi_bits) || !(|hi_bits));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) exc_q <= 1'b0;
    else          exc_q <= exc_d;
  end

  assign bus.data_exception = exc_q;
`else
  assign bus.data_exception = 1'b0;
`endif
endmodule
